// File: rtl/fir_mac_seq.sv
// fir_mac_seq -- sequential 8-tap FIR multiply-accumulate stage.
//
// On an accepted start the eight tap samples A0..A7 are snapshotted and
// y = sum(c[k] * A[k], k = 0..7) is computed one tap per clock with a single
// multiplier. The result is presented on y with a one-cycle y_valid pulse.
// Coefficients live in a local register file, writable while idle, and
// reset to 1 so that the default result is the plain sum of the taps.
//
// Ports:
//   clk        : clock, all registers update on its rising edge
//   resetn     : synchronous active-low reset (overrides enable)
//   enable     : global clock enable; 0 freezes all state except y_valid
//   start      : request one computation (accepted in IDLE with enable=1)
//   A0..A7     : DW-bit unsigned tap samples, A0 is the newest
//   coef_we    : coefficient write strobe (honoured in IDLE with enable=1)
//   coef_addr  : coefficient index k
//   coef_data  : CW-bit unsigned coefficient value
//   y          : last completed result (YW bits)
//   y_valid    : one-cycle pulse marking a new y
//   busy       : high while a computation is in progress
module fir_mac_seq #(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int YW = DW + CW + 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          start,
    input  logic [DW-1:0] A0,
    input  logic [DW-1:0] A1,
    input  logic [DW-1:0] A2,
    input  logic [DW-1:0] A3,
    input  logic [DW-1:0] A4,
    input  logic [DW-1:0] A5,
    input  logic [DW-1:0] A6,
    input  logic [DW-1:0] A7,
    input  logic          coef_we,
    input  logic [2:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic [YW-1:0] y,
    output logic          y_valid,
    output logic          busy
);

    typedef enum logic {
        IDLE,
        MAC
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [YW-1:0] acc;
    logic [DW-1:0] snap [8];
    logic [CW-1:0] coef [8];

    logic [DW+CW-1:0] prod;
    logic [YW-1:0]    prod_ext;
    logic [YW-1:0]    acc_next;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        prod     = {{CW{1'b0}}, snap[idx]} * {{DW{1'b0}}, coef[idx]};
        prod_ext = {{(YW-DW-CW){1'b0}}, prod};
        acc_next = acc + prod_ext;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            idx     <= 3'd0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            // NOTE: the coefficient file is reset because its reset value
            // (all ones) is functional; the snapshot needs no reset since it
            // is always reloaded before use.
            for (int k = 0; k < 8; k++) begin
                coef[k] <= CW'(1);
            end
        end else begin
            // The valid pulse ends after one cycle even when enable is low.
            y_valid <= 1'b0;

            if (enable) begin
                // Writes while busy are dropped. A write on the start edge
                // lands before E1, so the computation sees the new value.
                if (coef_we && state == IDLE) begin
                    coef[coef_addr] <= coef_data;
                end

                case (state)
                    IDLE: begin
                        if (start) begin
                            snap[0] <= A0;
                            snap[1] <= A1;
                            snap[2] <= A2;
                            snap[3] <= A3;
                            snap[4] <= A4;
                            snap[5] <= A5;
                            snap[6] <= A6;
                            snap[7] <= A7;
                            acc     <= '0;
                            idx     <= 3'd0;
                            busy    <= 1'b1;
                            state   <= MAC;
                        end
                    end
                    MAC: begin
                        acc <= acc_next;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            y       <= acc_next;
                            y_valid <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
